// File: rtl/iir_biquad_sched.sv
// Time-multiplexed Direct-Form-II biquad cascade scheduler driving one shared FP multiplier and one FP adder.
// Optional feature macro: IIR_SCHED_NAN_FLUSH_EN (flush non-finite section state and raise sticky ovf).
module iir_biquad_sched #(
    parameter int unsigned SECTIONS = 2,
    parameter int unsigned MULT_LAT = 5,
    parameter int unsigned ADD_LAT  = 7
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [31:0]                   in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [31:0]                   out_data,
    output logic [$clog2(5*SECTIONS)-1:0] coef_addr,
    input  logic [31:0]                   coef_data,
    output logic [31:0]                   mult_a,
    output logic [31:0]                   mult_b,
    input  logic [31:0]                   mult_q,
    output logic [31:0]                   add_a,
    output logic [31:0]                   add_b,
    output logic                          add_sub,
    input  logic [31:0]                   add_q,
    output logic                          ovf
);
    localparam int unsigned AW        = $clog2(5 * SECTIONS);
    localparam int unsigned SW        = (SECTIONS > 1) ? $clog2(SECTIONS) : 1;
    localparam int unsigned CW        = $clog2(MULT_LAT + 7);
    localparam int unsigned WW        = $clog2(ADD_LAT + 2);
    localparam int unsigned CAP_FIRST = 1 + MULT_LAT;
    localparam int unsigned CAP_LAST  = 5 + MULT_LAT;

    typedef enum logic [2:0] {IDLE, FETCH, MUL, MWAIT, ADD, DONE} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [WW-1:0] awt, awt_nx;
    logic [1:0]    add_idx, add_idx_nx;
    logic [SW-1:0] sec, sec_nx;
    logic [31:0]   x, x_nx;
    logic [31:0]   w_mid, w_mid_nx;
    logic [31:0]   prod    [5];
    logic [31:0]   prod_nx [5];
    logic [31:0]   w1    [SECTIONS];
    logic [31:0]   w1_nx [SECTIONS];
    logic [31:0]   w2    [SECTIONS];
    logic [31:0]   w2_nx [SECTIONS];
    logic [AW-1:0] coef_addr_nx;
    logic [31:0]   mult_a_nx, add_a_nx, add_b_nx, out_data_nx;
    logic          add_sub_nx, in_ready_nx, out_valid_nx, ovf_nx;

    // ROM data arrives exactly in the issue cycle, so it feeds the multiplier directly.
    assign mult_b = (state == MUL) ? coef_data : 32'd0;

    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        awt_nx       = awt;
        add_idx_nx   = add_idx;
        sec_nx       = sec;
        x_nx         = x;
        w_mid_nx     = w_mid;
        prod_nx      = prod;
        w1_nx        = w1;
        w2_nx        = w2;
        coef_addr_nx = coef_addr;
        mult_a_nx    = mult_a;
        add_a_nx     = add_a;
        add_b_nx     = add_b;
        add_sub_nx   = add_sub;
        out_valid_nx = out_valid;
        out_data_nx  = out_data;
        ovf_nx       = ovf;

        // Product j returns MULT_LAT cycles after its issue at section cycle 1+j.
        if ((state == MUL || state == MWAIT) && cnt >= CW'(CAP_FIRST) && cnt <= CW'(CAP_LAST))
            prod_nx[3'(cnt - CW'(CAP_FIRST))] = mult_q;

        unique case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    x_nx         = in_data;
                    sec_nx       = '0;
                    cnt_nx       = '0;
                    coef_addr_nx = '0;
                    state_nx     = FETCH;
                end
            end
            FETCH: begin
                state_nx     = MUL;
                cnt_nx       = CW'(1);
                mult_a_nx    = x;
                coef_addr_nx = coef_addr + AW'(1);
            end
            MUL: begin
                cnt_nx = cnt + CW'(1);
                if (cnt == CW'(5))
                    state_nx = MWAIT;
                else
                    mult_a_nx = cnt[0] ? w1[sec] : w2[sec];
                if (cnt < CW'(4))
                    coef_addr_nx = coef_addr + AW'(1);
            end
            MWAIT: begin
                if (cnt == CW'(CAP_LAST)) begin
                    state_nx   = ADD;
                    awt_nx     = '0;
                    add_idx_nx = '0;
                    add_a_nx   = prod[0];
                    add_b_nx   = prod[1];
                    add_sub_nx = 1'b1;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            ADD: begin
                if (awt == WW'(ADD_LAT)) begin
                    awt_nx     = '0;
                    add_idx_nx = add_idx + 2'd1;
                    add_a_nx   = add_q;
                    unique case (add_idx)
                        2'd0: begin
                            add_b_nx   = prod[2];
                            add_sub_nx = 1'b1;
                        end
                        2'd1: begin
                            w_mid_nx   = add_q;
                            add_b_nx   = prod[3];
                            add_sub_nx = 1'b0;
                        end
                        2'd2: begin
                            add_b_nx   = prod[4];
                            add_sub_nx = 1'b0;
                        end
                        default: begin
`ifdef IIR_SCHED_NAN_FLUSH_EN
                            if (w_mid[30:23] == 8'hFF) begin
                                w1_nx[sec] = '0;
                                w2_nx[sec] = '0;
                                ovf_nx     = 1'b1;
                            end else begin
                                w2_nx[sec] = w1[sec];
                                w1_nx[sec] = w_mid;
                            end
`else
                            w2_nx[sec] = w1[sec];
                            w1_nx[sec] = w_mid;
`endif
                            if (sec == SW'(SECTIONS - 1)) begin
                                out_data_nx  = add_q;
                                out_valid_nx = 1'b1;
                                state_nx     = DONE;
                            end else begin
                                sec_nx       = sec + SW'(1);
                                x_nx         = add_q;
                                cnt_nx       = '0;
                                coef_addr_nx = AW'(5 * (int'(sec) + 1));
                                state_nx     = FETCH;
                            end
                        end
                    endcase
                end else begin
                    awt_nx = awt + WW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_nx = 1'b0;
                    state_nx     = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase

        in_ready_nx = (state_nx == IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            awt       <= '0;
            add_idx   <= '0;
            sec       <= '0;
            x         <= '0;
            w_mid     <= '0;
            coef_addr <= '0;
            mult_a    <= '0;
            add_a     <= '0;
            add_b     <= '0;
            add_sub   <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            ovf       <= 1'b0;
            for (int i = 0; i < 5; i++) prod[i] <= '0;
            for (int k = 0; k < int'(SECTIONS); k++) begin
                w1[k] <= '0;
                w2[k] <= '0;
            end
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            awt       <= awt_nx;
            add_idx   <= add_idx_nx;
            sec       <= sec_nx;
            x         <= x_nx;
            w_mid     <= w_mid_nx;
            coef_addr <= coef_addr_nx;
            mult_a    <= mult_a_nx;
            add_a     <= add_a_nx;
            add_b     <= add_b_nx;
            add_sub   <= add_sub_nx;
            in_ready  <= in_ready_nx;
            out_valid <= out_valid_nx;
            out_data  <= out_data_nx;
            ovf       <= ovf_nx;
            prod      <= prod_nx;
            w1        <= w1_nx;
            w2        <= w2_nx;
        end
    end
endmodule

// File: tb/tb_iir_biquad_sched.sv
// Bench for iir_biquad_sched: models the coefficient ROM and pipelined FP units, checks against a per-sample DF-II reference.
module tb_iir_biquad_sched;
    localparam int SECTIONS = 2;
    localparam int MULT_LAT = 5;
    localparam int ADD_LAT  = 7;
    localparam int AW       = $clog2(5 * SECTIONS);
    localparam int D        = 6 + MULT_LAT + 4 * (ADD_LAT + 1);
    localparam int EXP_LAT  = 1 + SECTIONS * D;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [31:0]   in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [31:0]   out_data;
    logic [AW-1:0] coef_addr;
    logic [31:0]   coef_data = '0;
    logic [31:0]   mult_a, mult_b, mult_q;
    logic [31:0]   add_a, add_b, add_q;
    logic          add_sub;
    logic          ovf;

    int total = 0;
    int bad = 0;

    logic [31:0] rom [2**AW];
    logic [31:0] mp [MULT_LAT];
    logic [31:0] ap [ADD_LAT];
    logic [31:0] rw1 [SECTIONS];
    logic [31:0] rw2 [SECTIONS];
    logic        ref_ovf;

    iir_biquad_sched #(.SECTIONS(SECTIONS), .MULT_LAT(MULT_LAT), .ADD_LAT(ADD_LAT)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .coef_addr(coef_addr), .coef_data(coef_data),
        .mult_a(mult_a), .mult_b(mult_b), .mult_q(mult_q),
        .add_a(add_a), .add_b(add_b), .add_sub(add_sub), .add_q(add_q),
        .ovf(ovf)
    );

    always #5 clk = ~clk;

    // FP32 <-> real conversion; denormals flush to zero, rounding truncates.
    function automatic real f2r(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:23] == 8'h00)      d = {f[31], 63'b0};
        else if (f[30:23] == 8'hFF) d = {f[31], 11'h7FF, f[22:0], 29'b0};
        else                        d = {f[31], 11'(int'(f[30:23]) + 896), f[22:0], 29'b0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        logic [22:0] m;
        int          e;
        d = $realtobits(r);
        m = d[51:29];
        if (d[62:52] == 11'h7FF) begin
            if (d[51:0] != 52'd0 && m == 23'd0) m = 23'h400000;
            return {d[63], 8'hFF, m};
        end
        e = int'(d[62:52]) - 896;
        if (e <= 0)   return {d[63], 31'b0};
        if (e >= 255) return {d[63], 8'hFF, 23'b0};
        return {d[63], 8'(e), m};
    endfunction

    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        return r2f(f2r(a) * f2r(b));
    endfunction

    function automatic logic [31:0] faddsub(input logic [31:0] a, input logic [31:0] b, input logic sub);
        return sub ? r2f(f2r(a) - f2r(b)) : r2f(f2r(a) + f2r(b));
    endfunction

    // External ROM and arithmetic unit models
    always @(posedge clk) coef_data <= rom[coef_addr];

    always @(posedge clk) begin
        mp[0] <= fmul(mult_a, mult_b);
        for (int i = 1; i < MULT_LAT; i++) mp[i] <= mp[i-1];
        ap[0] <= faddsub(add_a, add_b, add_sub);
        for (int i = 1; i < ADD_LAT; i++) ap[i] <= ap[i-1];
    end
    assign mult_q = mp[MULT_LAT-1];
    assign add_q  = ap[ADD_LAT-1];

    // Reference: one full cascade evaluation per sample
    function automatic logic [31:0] ref_filter(input logic [31:0] xin);
        logic [31:0] v, p0, p1, p2, p3, p4, t, w, u;
        v = xin;
        for (int k = 0; k < SECTIONS; k++) begin
            p0 = fmul(v, rom[5*k]);
            p1 = fmul(rw1[k], rom[5*k+1]);
            p2 = fmul(rw2[k], rom[5*k+2]);
            p3 = fmul(rw1[k], rom[5*k+3]);
            p4 = fmul(rw2[k], rom[5*k+4]);
            t  = faddsub(p0, p1, 1'b1);
            w  = faddsub(t, p2, 1'b1);
            u  = faddsub(w, p3, 1'b0);
            v  = faddsub(u, p4, 1'b0);
`ifdef IIR_SCHED_NAN_FLUSH_EN
            if (w[30:23] == 8'hFF) begin
                rw1[k] = '0;
                rw2[k] = '0;
                ref_ovf = 1'b1;
            end else begin
                rw2[k] = rw1[k];
                rw1[k] = w;
            end
`else
            rw2[k] = rw1[k];
            rw1[k] = w;
`endif
        end
        return v;
    endfunction

    function automatic logic [31:0] rand_fp(input int lo, input int hi);
        logic [31:0] r;
        r[31]    = 1'($urandom);
        r[30:23] = 8'($urandom_range(hi, lo));
        r[22:0]  = 23'($urandom);
        return r;
    endfunction

    task automatic clear_ref();
        for (int k = 0; k < SECTIONS; k++) begin
            rw1[k] = '0;
            rw2[k] = '0;
        end
        ref_ovf = 1'b0;
    endtask

    task automatic set_rom(input bit recursive);
        for (int i = 0; i < 2**AW; i++) rom[i] = '0;
        for (int k = 0; k < SECTIONS; k++) rom[5*k] = 32'h3F800000;
        if (recursive) rom[1] = 32'hBF000000;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        clear_ref();
    endtask

    // Push one sample, wait for the result, accept it; ok=0 on any timeout.
    task automatic run_sample(input logic [31:0] xin, input bit early_ready,
                              output logic [31:0] y, output int lat, output bit ok);
        int n;
        ok = 1'b0;
        y = '0;
        lat = 0;
        n = 0;
        while (in_ready !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (in_ready !== 1'b1) return;
        out_ready = early_ready;
        in_data = xin;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_data = $urandom;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 2000) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        if (out_valid !== 1'b1) return;
        y = out_data;
        if (!early_ready) begin
            repeat (2) @(negedge clk);
            out_ready = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        ok = 1'b1;
    endtask

    task automatic test_reset();
        logic [233:0] v;
        repeat (3) @(negedge clk);
        #1;
        v = {in_ready, out_valid, ovf, add_sub, out_data, mult_a, mult_b, add_a, add_b, 32'(coef_addr), 10'd0};
        total++;
        if (v !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got %h required 0", v);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_release_ready_early: got %b required 0", in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_release_ready: got %b required 1", in_ready);
        end
        clear_ref();
    endtask

    task automatic test_passthrough();
        logic [31:0] y, mdl;
        int lat;
        bit ok;
        set_rom(1'b0);
        mdl = ref_filter(32'h40400000);
        run_sample(32'h40400000, 1'b0, y, lat, ok);
        total++;
        if (!ok || y !== 32'h40400000 || mdl !== 32'h40400000) begin
            bad++;
            $display("FAIL passthrough_data: ok=%0b got %h model %h required 40400000", ok, y, mdl);
        end
        total++;
        if (lat !== EXP_LAT) begin
            bad++;
            $display("FAIL passthrough_latency: got %0d required %0d", lat, EXP_LAT);
        end
    endtask

    task automatic test_recursion();
        logic [31:0] xs [3];
        logic [31:0] es [3];
        logic [31:0] y, mdl;
        int lat;
        bit ok;
        xs = '{32'h3F800000, 32'h00000000, 32'h00000000};
        es = '{32'h3F800000, 32'h3F000000, 32'h3E800000};
        do_reset();
        set_rom(1'b1);
        for (int i = 0; i < 3; i++) begin
            mdl = ref_filter(xs[i]);
            run_sample(xs[i], i[0], y, lat, ok);
            total++;
            if (!ok || y !== es[i]) begin
                bad++;
                $display("FAIL recursion_out%0d: ok=%0b got %h required %h", i, ok, y, es[i]);
            end
            total++;
            if (y !== mdl) begin
                bad++;
                $display("FAIL recursion_model%0d: got %h required %h", i, y, mdl);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] x, y, mdl;
        int lat;
        bit ok;
        for (int k = 0; k < SECTIONS; k++) begin
            rom[5*k]   = rand_fp(120, 127);
            rom[5*k+1] = rand_fp(118, 125);
            rom[5*k+2] = rand_fp(118, 125);
            rom[5*k+3] = rand_fp(120, 127);
            rom[5*k+4] = rand_fp(120, 127);
        end
        for (int n = 0; n < 8; n++) begin
            x = rand_fp(120, 130);
            mdl = ref_filter(x);
            run_sample(x, 1'($urandom), y, lat, ok);
            total++;
            if (!ok || y !== mdl || lat !== EXP_LAT) begin
                bad++;
                $display("FAIL random_sample%0d: ok=%0b got %h lat %0d required %h lat %0d", n, ok, y, lat, mdl, EXP_LAT);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] x, mdl, held, y;
        int n, lat;
        bit ok;
        x = rand_fp(120, 130);
        mdl = ref_filter(x);
        n = 0;
        while (in_ready !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        out_ready = 1'b0;
        in_data = x;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        n = 1;
        while (out_valid !== 1'b1 && n < 2000) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        total++;
        if (out_valid !== 1'b1 || out_data !== mdl) begin
            bad++;
            $display("FAIL bp_first: valid=%b got %h required %h", out_valid, out_data, mdl);
        end
        held = out_data;
        in_valid = 1'b1;
        in_data = rand_fp(120, 130);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            @(negedge clk);
            total++;
            if (out_valid !== 1'b1 || out_data !== held || in_ready !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold%0d: valid=%b data=%h ready=%b required 1 %h 0", c, out_valid, out_data, in_ready, held);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_release: valid=%b ready=%b required 0 1", out_valid, in_ready);
        end
        x = rand_fp(120, 130);
        mdl = ref_filter(x);
        run_sample(x, 1'b1, y, lat, ok);
        total++;
        if (!ok || y !== mdl) begin
            bad++;
            $display("FAIL bp_next: ok=%0b got %h required %h", ok, y, mdl);
        end
    endtask

    task automatic test_reset_mid();
        logic [233:0] v;
        logic [31:0] y;
        int lat, n;
        bit ok, seen;
        n = 0;
        while (in_ready !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        in_data = rand_fp(120, 130);
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (19) @(negedge clk);
        reset = 1'b1;
        #1;
        v = {in_ready, out_valid, ovf, add_sub, out_data, mult_a, mult_b, add_a, add_b, 32'(coef_addr), 10'd0};
        total++;
        if (v !== '0) begin
            bad++;
            $display("FAIL midreset_outputs: got %h required 0", v);
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        clear_ref();
        seen = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL midreset_quiet: out_valid_seen=%b ready=%b required 0 1", seen, in_ready);
        end
        set_rom(1'b1);
        void'(ref_filter(32'h3F800000));
        run_sample(32'h3F800000, 1'b1, y, lat, ok);
        total++;
        if (!ok || y !== 32'h3F800000) begin
            bad++;
            $display("FAIL midreset_impulse0: ok=%0b got %h required 3f800000", ok, y);
        end
        void'(ref_filter(32'h00000000));
        run_sample(32'h00000000, 1'b0, y, lat, ok);
        total++;
        if (!ok || y !== 32'h3F000000) begin
            bad++;
            $display("FAIL midreset_impulse1: ok=%0b got %h required 3f000000", ok, y);
        end
    endtask

`ifdef IIR_SCHED_NAN_FLUSH_EN
    task automatic test_nan_flush();
        logic [31:0] y, mdl;
        int lat;
        bit ok;
        do_reset();
        set_rom(1'b1);
        total++;
        if (ovf !== 1'b0) begin
            bad++;
            $display("FAIL nan_ovf_clear: got %b required 0", ovf);
        end
        mdl = ref_filter(32'h7FC00000);
        run_sample(32'h7FC00000, 1'b1, y, lat, ok);
        total++;
        if (!ok || y !== mdl || ovf !== ref_ovf || ovf !== 1'b1) begin
            bad++;
            $display("FAIL nan_sample: ok=%0b got %h ovf %b required %h ovf 1", ok, y, ovf, mdl);
        end
        mdl = ref_filter(32'h3F800000);
        run_sample(32'h3F800000, 1'b1, y, lat, ok);
        total++;
        if (!ok || y !== 32'h3F800000 || y !== mdl || ovf !== 1'b1) begin
            bad++;
            $display("FAIL nan_flushed: ok=%0b got %h ovf %b required 3f800000 ovf 1", ok, y, ovf);
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < MULT_LAT; i++) mp[i] = '0;
        for (int i = 0; i < ADD_LAT; i++) ap[i] = '0;
        for (int i = 0; i < 2**AW; i++) rom[i] = '0;
        clear_ref();
        test_reset();
        test_passthrough();
        test_recursion();
        test_random();
        test_backpressure();
        test_reset_mid();
`ifdef IIR_SCHED_NAN_FLUSH_EN
        test_nan_flush();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/iir_biquad_sched.md
# iir_biquad_sched

Time-multiplexed scheduler that runs a cascade of Direct-Form-II biquad sections on one shared pipelined FP_MULT and one shared FP_ADD/SUB unit, in place of one dedicated operator per coefficient. Accepts one IEEE-754 single-precision sample per valid/ready handshake, sequences all sections, and presents the filtered sample on a valid/ready output. Owns the per-section delay state and drives the coefficient ROM address; the arithmetic units and ROM are instantiated outside.

## Interface
- SECTIONS, 2: number of cascaded biquad sections, 1..8.
- MULT_LAT, 5: fixed FP_MULT latency in cycles (en tied high).
- ADD_LAT, 7: fixed FP_ADD/SUB latency in cycles.
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  scheduler idle, sample accepted when in_valid & in_ready.
- in_data  in  32  input sample, FP32.
- out_valid  out  1  filtered sample valid, held until accepted.
- out_ready  in  1  downstream accepts.
- out_data  out  32  filtered sample, FP32.
- coef_addr  out  $clog2(5*SECTIONS)  ROM address = 5*section + j, j order S, A2, A3, B2, B3.
- coef_data  in  32  ROM data, valid one cycle after coef_addr.
- mult_a, mult_b  out  32  multiplier operands.
- mult_q  in  32  multiplier result.
- add_a, add_b  out  32  adder operands.
- add_sub  out  1  1 = a-b, 0 = a+b.
- add_q  in  32  adder result.
- ovf  out  1  sticky non-finite-state flag (see Configuration).

## Operation
- States: IDLE, FETCH, MUL, MWAIT, ADD, DONE. in_ready = 1 only in IDLE.
- Per section k with input x (in_data for k=0, previous section y otherwise), state w1[k], w2[k]:
  - Products P0..P4 = S*x, A2*w1, A3*w2, B2*w1, B3*w2.
  - t = P0 - P1; w = t - P2; u = w + P3; y = u + P4 (adds strictly serial).
  - At section end: w2[k] <= w1[k]; w1[k] <= w.
- After last section: out_data <= y, out_valid <= 1, state DONE; return to IDLE on out_valid & out_ready.
- State registers: 2*SECTIONS words, reset to 0. Operand/product regs are don't-care outside use.
- Arithmetic is never performed internally; all FP ops go through the shared units.

## Timing
- Handshake at cycle 0; section 0 starts T0 = 1; section k starts Tk = T0 + k*D.
- coef_addr for op j at Tk+j (j=0..4); mult issued Tk+1+j (mult_b = coef_data, registered path allowed only if latency preserved); P_j captured from mult_q at Tk+1+j+MULT_LAT.
- Add 0 issued Tk+6+MULT_LAT; each add occupies ADD_LAT+1 cycles (issue, wait, capture), next add issued the cycle after capture.
- D = 6 + MULT_LAT + 4*(ADD_LAT+1); defaults D = 43.
- out_valid rises at cycle 1 + SECTIONS*D (defaults: 87).
- out_valid low with out_ready high: no effect. out_valid high: out_data stable until accepted; no new input accepted.
- Reset asserted any cycle (including mid-section): immediately IDLE, all outputs 0 (in_ready 0, out_valid 0, ovf 0, operands 0), state registers 0; in results arriving after reset ignored. in_ready = 1 on first rising edge after reset release.

## Configuration
- IIR_SCHED_NAN_FLUSH_EN defined: at section end, if w exponent == 8'hFF (Inf/NaN), w1[k] and w2[k] are written 0 instead of the shift, and ovf set (sticky until reset); y still forwarded unmodified.
- Undefined: state always shifted as-is; ovf tied 0.

## Test plan
- Reset: hold reset 3 cycles mid-traffic -> all outputs 0; in_ready 1 at first edge after release.
- Passthrough, SECTIONS=2, S=1.0 (0x3F800000), A/B=0: in 0x40400000 -> out_data 0x40400000, out_valid at cycle 87 after handshake.
- Recursion: section 0 S=1.0, A2=-0.5 (0xBF000000), rest 0; section 1 passthrough: inputs 1.0, 0, 0 -> outputs 0x3F800000, 0x3F000000, 0x3E800000.
- Backpressure: out_ready low 10 cycles after out_valid -> out_data stable, in_ready 0, asserted in_valid not accepted; accept on out_ready.
- Reset at cycle 20 of a sample: no out_valid; next impulse 1.0 reproduces clean response 1.0, 0.5.
- With IIR_SCHED_NAN_FLUSH_EN: input 0x7FC00000 -> ovf 1; following 1.0 with recursion config -> out 0x3F800000 (state flushed).
